// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives one column at a time, samples synchronized rows,
// debounces each frame result and shifts accepted hex codes into a value register.
module keypad_scanner #(
    parameter int N        = 8,
    parameter int SETTLE   = 10000,
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         reset,
    output logic [3:0]   col,
    input  logic [3:0]   row,
    output logic [3:0]   key_code,
    output logic         key_valid,
    output logic         key_held,
    output logic [N-1:0] value
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);

    typedef enum logic [0:0] {ST_SCAN = 1'b0, ST_EVAL = 1'b1} state_t;
    typedef enum logic [1:0] {RES_NONE = 2'd0, RES_KEY = 2'd1, RES_MULTI = 2'd2} kind_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h2;
            4'b00_10: key_map = 4'h3;
            4'b00_11: key_map = 4'hA;
            4'b01_00: key_map = 4'h4;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h6;
            4'b01_11: key_map = 4'hB;
            4'b10_00: key_map = 4'h7;
            4'b10_01: key_map = 4'h8;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hC;
            4'b11_00: key_map = 4'h0;
            4'b11_01: key_map = 4'hF;
            4'b11_10: key_map = 4'hE;
            4'b11_11: key_map = 4'hD;
            default:  key_map = 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    col_drive = 4'b1110;
            2'd1:    col_drive = 4'b1101;
            2'd2:    col_drive = 4'b1011;
            default: col_drive = 4'b0111;
        endcase
    endfunction

    logic [3:0]    r_sync1, r_sync2;
    state_t        r_state;
    logic          r_run;
    logic [1:0]    r_col_idx;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_col;
    logic [15:0]   r_hits;
    kind_t         r_cand_kind, r_rep_kind;
    logic [3:0]    r_cand_code, r_rep_code;
    logic [DW-1:0] r_stable;
    logic [3:0]    r_key_code;
    logic          r_key_valid, r_key_held;
    logic [N-1:0]  r_value;

    logic [4:0]    w_hit_cnt;
    logic [3:0]    w_hit_code, w_res_code;
    kind_t         w_res_kind;
    logic          w_same, w_accept_key, w_accept_none;
    logic [DW-1:0] w_stable_nxt;

    // Row synchronizer: rows come straight from the keypad pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
        end
    end

    // Classify the frame: hit bit index is {col, row}, so a single hit names its key.
    always_comb begin
        w_hit_cnt  = 5'd0;
        w_hit_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            w_hit_cnt  = w_hit_cnt + {4'd0, r_hits[i]};
            w_hit_code = r_hits[i] ? key_map(i[1:0], i[3:2]) : w_hit_code;
        end
        case (w_hit_cnt)
            5'd0: begin
                w_res_kind = RES_NONE;
                w_res_code = 4'h0;
            end
            5'd1: begin
                w_res_kind = RES_KEY;
                w_res_code = w_hit_code;
            end
            default: begin
                w_res_kind = RES_MULTI;
                w_res_code = 4'h0;
            end
        endcase
    end

    // Debounce update and acceptance decision, applied at the EVAL edge.
    always_comb begin
        w_same        = (w_res_kind == r_cand_kind) && (w_res_code == r_cand_code);
        w_stable_nxt  = w_same ? ((r_stable == DEB_MAX) ? DEB_MAX : r_stable + DEB_ONE) : DEB_ONE;
        w_accept_key  = (w_stable_nxt == DEB_MAX) && (w_res_kind == RES_KEY) &&
                        !((r_rep_kind == RES_KEY) && (r_rep_code == w_res_code));
        w_accept_none = (w_stable_nxt == DEB_MAX) && (w_res_kind == RES_NONE);
    end

    // Scan FSM with debounce state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SCAN;
            r_run       <= 1'b0;
            r_col_idx   <= 2'd0;
            r_cnt       <= '0;
            r_col       <= 4'b1111;
            r_hits      <= 16'h0000;
            r_cand_kind <= RES_NONE;
            r_cand_code <= 4'h0;
            r_stable    <= '0;
            r_rep_kind  <= RES_NONE;
            r_rep_code  <= 4'h0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_value     <= '0;
        end else begin
            r_key_valid <= 1'b0;
            if (!r_run) begin
                r_run     <= 1'b1;
                r_state   <= ST_SCAN;
                r_col_idx <= 2'd0;
                r_cnt     <= '0;
                r_col     <= col_drive(2'd0);
            end else begin
                case (r_state)
                    ST_SCAN: begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt <= '0;
                            r_hits[{r_col_idx, 2'b00} +: 4] <= ~r_sync2;
                            if (r_col_idx == 2'd3) begin
                                r_state <= ST_EVAL;
                            end else begin
                                r_col_idx <= r_col_idx + 2'd1;
                                r_col     <= col_drive(r_col_idx + 2'd1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    ST_EVAL: begin
                        r_state     <= ST_SCAN;
                        r_col_idx   <= 2'd0;
                        r_col       <= col_drive(2'd0);
                        r_cand_kind <= w_res_kind;
                        r_cand_code <= w_res_code;
                        r_stable    <= w_stable_nxt;
                        if (w_accept_key) begin
                            r_key_valid <= 1'b1;
                            r_key_code  <= w_res_code;
                            r_key_held  <= 1'b1;
                            r_value     <= (r_value << 3'd4) | N'(w_res_code);
                            r_rep_kind  <= RES_KEY;
                            r_rep_code  <= w_res_code;
                        end else if (w_accept_none) begin
                            r_rep_kind  <= RES_NONE;
                            r_rep_code  <= 4'h0;
                            r_key_held  <= 1'b0;
                        end else begin
                            r_rep_kind  <= r_rep_kind;
                        end
                    end
                    default: r_state <= ST_SCAN;
                endcase
            end
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign value     = r_value;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, frame-level reference model,
// per-cycle comparison plus hand-computed checkpoints.
module tb_keypad_scanner;
    localparam int SETTLE = 4;
    localparam int DEB    = 2;
    localparam int NW     = 8;
    localparam int FRAME  = 4 * SETTLE + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    col;
    logic [3:0]    row;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_held;
    logic [NW-1:0] value;

    logic [15:0]   keys = 16'h0000;   // pressed keys, bit r*4+c
    logic [3:0]    kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    int n_vec = 0;
    int n_fail = 0;
    int n_pulses = 0;

    // reference model state
    bit          m_run;
    int          m_t, m_p, m_rep, hist_n;
    int          hist [DEB];
    logic [3:0]  m_col, m_code;
    logic        m_valid, m_held;
    logic [NW-1:0] m_value;

    keypad_scanner #(.N(NW), .SETTLE(SETTLE), .DEBOUNCE(DEB)) dut (
        .clk(clk), .reset(reset), .col(col), .row(row), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held), .value(value)
    );

    always #5 clk = ~clk;

    // A row reads low when a pressed key sits on a column currently driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    task automatic eval_frame();
        int n = 0;
        int code = 0;
        int res;
        bit stable;
        for (int i = 0; i < 16; i++) begin
            if (keys[i]) begin
                n++;
                code = int'(kmap[i]);
            end
        end
        res = (n == 0) ? -1 : ((n == 1) ? code : -2);
        for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = res;
        if (hist_n < DEB) hist_n++;
        stable = (hist_n == DEB);
        for (int i = 0; i < DEB; i++) if (hist[i] != res) stable = 0;
        if (stable && res >= 0 && m_rep != res) begin
            m_valid = 1'b1;
            m_code  = 4'(res);
            m_value = {m_value[NW-5:0], 4'(res)};
            m_held  = 1'b1;
            m_rep   = res;
        end else if (stable && res == -1) begin
            m_rep  = -1;
            m_held = 1'b0;
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            m_run = 0; m_t = 0; m_p = 0; m_rep = -1; hist_n = 0;
            m_col = 4'hF; m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_value = '0;
        end else begin
            m_valid = 1'b0;
            if (m_run && (m_t % FRAME) == FRAME - 1) eval_frame();
            if (!m_run) begin
                m_run = 1;
                m_t = 0;
            end else begin
                m_t++;
            end
            m_p   = m_t % FRAME;
            m_col = (m_p == FRAME - 1) ? 4'b0111 : ~(4'b0001 << (m_p / SETTLE));
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or negedge reset);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("col", 8'(col), 8'(m_col));
        chk("key_code", 8'(key_code), 8'(m_code));
        chk("key_valid", 8'(key_valid), 8'(m_valid));
        chk("key_held", 8'(key_held), 8'(m_held));
        chk("value", 8'(value), 8'(m_value));
        if (key_valid === 1'b1) n_pulses++;
    endtask

    // Align to the first cycle of a frame, apply a key set, hold it n frames.
    task automatic run(input logic [15:0] k, input int n);
        int guard = 0;
        while (!(m_run && m_p == 0)) begin
            tick();
            guard++;
            if (guard > 4 * FRAME) begin
                n_vec++;
                n_fail++;
                $display("FAIL frame_align: no frame start within %0d cycles", guard);
                break;
            end
        end
        keys = k;
        repeat (n * FRAME) tick();
    endtask

    initial begin
        int p0;
        repeat (3) tick();
        chk("rst_col", 8'(col), 8'h0F);
        chk("rst_value", 8'(value), 8'h00);
        chk("rst_held", 8'(key_held), 8'h00);
        #2 reset = 1'b1;

        // 1: idle scan
        p0 = n_pulses;
        run(16'h0000, 3);
        chk("t1_col_c0", 8'(col), 8'h0E);
        repeat (4) tick();
        chk("t1_col_c1", 8'(col), 8'h0D);
        repeat (4) tick();
        chk("t1_col_c2", 8'(col), 8'h0B);
        repeat (8) tick();
        chk("t1_col_eval", 8'(col), 8'h07);
        tick();
        chk("t1_col_wrap", 8'(col), 8'h0E);
        chk("t1_pulses", 8'(n_pulses - p0), 8'd0);
        chk("t1_value", 8'(value), 8'h00);

        // 2: key 5
        p0 = n_pulses;
        run(16'h0020, 1);
        chk("t2_no_pulse_yet", 8'(key_valid), 8'h00);
        chk("t2_held_yet", 8'(key_held), 8'h00);
        run(16'h0020, 1);
        chk("t2_pulse_now", 8'(key_valid), 8'h01);
        run(16'h0020, 3);
        chk("t2_pulses", 8'(n_pulses - p0), 8'd1);
        chk("t2_code", 8'(key_code), 8'h05);
        chk("t2_value", 8'(value), 8'h05);
        chk("t2_held", 8'(key_held), 8'h01);

        // 3: release, then A
        run(16'h0000, 1);
        chk("t3_held_1none", 8'(key_held), 8'h01);
        run(16'h0000, 1);
        chk("t3_held_2none", 8'(key_held), 8'h00);
        run(16'h0000, 1);
        p0 = n_pulses;
        run(16'h0008, 3);
        chk("t3_pulses", 8'(n_pulses - p0), 8'd1);
        chk("t3_code", 8'(key_code), 8'h0A);
        chk("t3_value", 8'(value), 8'h5A);
        run(16'h0000, 2);

        // 4: bouncing 7
        p0 = n_pulses;
        repeat (3) begin
            run(16'h0100, 1);
            run(16'h0000, 1);
        end
        chk("t4_pulses", 8'(n_pulses - p0), 8'd0);
        chk("t4_value", 8'(value), 8'h5A);

        // 5: 1+2 together, then 1 alone, then 2 added and removed again
        p0 = n_pulses;
        run(16'h0003, 4);
        chk("t5_multi_pulses", 8'(n_pulses - p0), 8'd0);
        chk("t5_multi_held", 8'(key_held), 8'h00);
        run(16'h0001, 3);
        chk("t5_pulses", 8'(n_pulses - p0), 8'd1);
        chk("t5_code", 8'(key_code), 8'h01);
        chk("t5_value", 8'(value), 8'hA1);
        p0 = n_pulses;
        run(16'h0003, 3);
        chk("t5_multi_held1", 8'(key_held), 8'h01);
        run(16'h0001, 3);
        chk("t5_no_repeat", 8'(n_pulses - p0), 8'd0);

        // 6: rollover to 9, then reset while held
        p0 = n_pulses;
        run(16'h0400, 3);
        chk("t6_rollover", 8'(n_pulses - p0), 8'd1);
        chk("t6_value_pre", 8'(value), 8'h19);
        repeat (5) tick();
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_col", 8'(col), 8'h0F);
        chk("t6_rst_code", 8'(key_code), 8'h00);
        chk("t6_rst_held", 8'(key_held), 8'h00);
        chk("t6_rst_value", 8'(value), 8'h00);
        repeat (3) tick();
        #2 reset = 1'b1;
        p0 = n_pulses;
        run(16'h0400, 2);
        chk("t6_pulse_now", 8'(key_valid), 8'h01);
        chk("t6_code", 8'(key_code), 8'h09);
        chk("t6_value", 8'(value), 8'h09);
        run(16'h0000, 2);
        chk("t6_pulses", 8'(n_pulses - p0), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
